hostaddress_table: RTL and testbench

//  Parametrised host-address value store for the FIX parser. It replaces the plain single-port RAM with:
//  - independent write and read ports
//  - per-entry valid bits and an occupancy count
//  - selectable read-during-write policy and optional output register
//  - a sequenced table-clear FSM
//  The tag decoder writes into it and the message assembler reads from it.

---
 rtl/hostaddress_table_pkg.sv | 13 +
 rtl/hostaddress_sdp_ram.sv | 25 ++
 rtl/hostaddress_table.sv | 156 +++++++++++++++
 tb/tb_hostaddress_table.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hostaddress_table_pkg.sv
// Shared widths and clear-FSM state encodings for the host-address value store.
package hostaddress_table_pkg;

  localparam int HOST_ADDR_WIDTH  = 4;
  localparam int VALUE_DATA_WIDTH = 12;
  localparam int VALUE_SIZE       = 4;

  typedef enum logic {
    HT_ST_IDLE  = 1'b0,
    HT_ST_CLEAR = 1'b1
  } ht_state_e;

endpackage

// File: rtl/hostaddress_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset.
// The read samples memory at the clock edge, so a same-address write in that cycle is not seen.
module hostaddress_sdp_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/hostaddress_table.sv
// Host-address value store: SDP RAM plus per-entry valid bits, occupancy count,
// read-during-write policy, optional output register and a sequenced clear sweep.
module hostaddress_table
  import hostaddress_table_pkg::*;
#(
  parameter int ADDR_WIDTH  = HOST_ADDR_WIDTH,
  parameter int DATA_WIDTH  = VALUE_DATA_WIDTH + VALUE_SIZE,
  parameter bit WRITE_FIRST = 1'b1,
  parameter bit OUT_REG     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_hit,
  input  logic                  clr_start,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   entry_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  ht_state_e             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_wr_ready;
  logic                  w_busy, w_wr_acc, w_clr_go, w_sweep_end;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [DATA_WIDTH-1:0] w_ram_wdata, w_ram_rdata;
  logic                  w_same, w_hit_p0, w_byp_p0;
  logic                  r_vld_p1, r_hit_p1, r_byp_p1;
  logic [DATA_WIDTH-1:0] r_wdat_p1, w_data_p1;

  assign w_busy      = (r_state == HT_ST_CLEAR);
  assign w_wr_acc    = wr_en & r_wr_ready;
  assign w_sweep_end = (r_ptr == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_clr_go    = 1'b0;
    case (r_state)
      HT_ST_IDLE: begin
        if (clr_start) begin
          w_state_nxt = HT_ST_CLEAR;
          w_clr_go    = 1'b1;
        end
      end
      HT_ST_CLEAR: begin
        if (w_sweep_end) w_state_nxt = HT_ST_IDLE;
      end
    endcase
  end

  // wr_ready is a flop so it stays low while reset is asserted and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HT_ST_IDLE;
      r_wr_ready <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ready <= (w_state_nxt == HT_ST_IDLE);
      if (w_clr_go)    r_ptr <= '0;
      else if (w_busy) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      if (w_busy)        r_valid[r_ptr]   <= 1'b0;
      else if (w_wr_acc) r_valid[wr_addr] <= 1'b1;
      // A write in the clr_start cycle lands in r_valid but the count restarts at zero.
      if (w_clr_go)                            r_count <= '0;
      else if (w_wr_acc && !r_valid[wr_addr])  r_count <= r_count + 1'b1;
    end
  end

  assign w_ram_we    = w_busy | w_wr_acc;
  assign w_ram_waddr = w_busy ? r_ptr : wr_addr;
  assign w_ram_wdata = w_busy ? '0 : wr_data;

  hostaddress_sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_ram_we),
    .wr_addr (w_ram_waddr),
    .wr_data (w_ram_wdata),
    .rd_addr (rd_addr),
    .rd_data (w_ram_rdata)
  );

  // ---- stage p0 -> p1: sample valid bit and bypass decision at request time ----
  assign w_same   = w_wr_acc & (wr_addr == rd_addr);
  assign w_byp_p0 = WRITE_FIRST & w_same;
  assign w_hit_p0 = rd_en & ~w_busy & (r_valid[rd_addr] | w_byp_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_hit_p1  <= 1'b0;
      r_byp_p1  <= 1'b0;
      r_wdat_p1 <= '0;
    end else begin
      r_vld_p1  <= rd_en;
      r_hit_p1  <= w_hit_p0;
      r_byp_p1  <= w_byp_p0;
      r_wdat_p1 <= wr_data;
    end
  end

  assign w_data_p1 = !r_hit_p1 ? '0 : (r_byp_p1 ? r_wdat_p1 : w_ram_rdata);

  // ---- stage p1 -> p2: optional output register ----
  generate
    if (OUT_REG) begin : g_out_reg
      logic                  r_vld_p2, r_hit_p2;
      logic [DATA_WIDTH-1:0] r_data_p2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_p2  <= 1'b0;
          r_hit_p2  <= 1'b0;
          r_data_p2 <= '0;
        end else begin
          r_vld_p2  <= r_vld_p1;
          r_hit_p2  <= r_hit_p1;
          r_data_p2 <= w_data_p1;
        end
      end
      assign rd_valid = r_vld_p2;
      assign rd_hit   = r_hit_p2;
      assign rd_data  = r_data_p2;
    end else begin : g_no_out_reg
      assign rd_valid = r_vld_p1;
      assign rd_hit   = r_hit_p1;
      assign rd_data  = w_data_p1;
    end
  endgenerate

  assign wr_ready    = r_wr_ready;
  assign busy        = w_busy;
  assign entry_count = r_count;

endmodule

// File: tb/tb_hostaddress_table.sv
// Bench for hostaddress_table: three variants (write-first, read-first, output-registered)
// share one stimulus stream and are checked against a table-level behavioural model.
module tb_hostaddress_table;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        clr_start = 1'b0;

  logic        wf_wr_ready, wf_rd_valid, wf_rd_hit, wf_busy;
  logic [15:0] wf_rd_data;
  logic [4:0]  wf_entry_count;
  logic        rf_wr_ready, rf_rd_valid, rf_rd_hit, rf_busy;
  logic [15:0] rf_rd_data;
  logic [4:0]  rf_entry_count;
  logic        or_wr_ready, or_rd_valid, or_rd_hit, or_busy;
  logic [15:0] or_rd_data;
  logic [4:0]  or_entry_count;

  always #5 clk = ~clk;

  hostaddress_table #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WRITE_FIRST(1'b1), .OUT_REG(1'b0)) u_wf (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wf_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(wf_rd_valid),
    .rd_data(wf_rd_data), .rd_hit(wf_rd_hit), .clr_start(clr_start), .busy(wf_busy),
    .entry_count(wf_entry_count));

  hostaddress_table #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WRITE_FIRST(1'b0), .OUT_REG(1'b0)) u_rf (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rf_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rf_rd_valid),
    .rd_data(rf_rd_data), .rd_hit(rf_rd_hit), .clr_start(clr_start), .busy(rf_busy),
    .entry_count(rf_entry_count));

  hostaddress_table #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WRITE_FIRST(1'b1), .OUT_REG(1'b1)) u_or (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(or_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(or_rd_valid),
    .rd_data(or_rd_data), .rd_hit(or_rd_hit), .clr_start(clr_start), .busy(or_busy),
    .entry_count(or_entry_count));

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: contents, validity, occupancy and remaining sweep length.
  logic [15:0] m_mem [DEPTH];
  bit          m_valid [DEPTH];
  int          m_count;
  int          m_clr_left;
  bit          m_ready;
  bit          e1_vld, e1_hit_wf, e1_hit_rf, e2_vld, e2_hit;
  logic [15:0] e1_dat_wf, e1_dat_rf, e2_dat;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_count = 0; m_clr_left = 0; m_ready = 1'b0;
    e1_vld = 0; e1_hit_wf = 0; e1_hit_rf = 0; e1_dat_wf = '0; e1_dat_rf = '0;
    e2_vld = 0; e2_hit = 0; e2_dat = '0;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
  endtask

  // Advance one clock with the currently driven inputs; check every variant afterwards.
  task automatic cycle();
    bit busy_m, wacc, same, h_rf, h_wf;
    logic [15:0] d_rf, d_wf;
    busy_m = (m_clr_left > 0);
    wacc   = wr_en && m_ready;
    same   = wacc && (wr_addr == rd_addr);
    h_rf   = rd_en && !busy_m && m_valid[rd_addr];
    h_wf   = rd_en && !busy_m && (m_valid[rd_addr] || same);
    d_rf   = h_rf ? m_mem[rd_addr] : 16'h0;
    d_wf   = h_wf ? (same ? wr_data : m_mem[rd_addr]) : 16'h0;
    e2_vld = e1_vld; e2_hit = e1_hit_wf; e2_dat = e1_dat_wf;
    e1_vld = rd_en; e1_hit_wf = h_wf; e1_dat_wf = d_wf; e1_hit_rf = h_rf; e1_dat_rf = d_rf;
    if (wacc) begin
      if (!m_valid[wr_addr]) m_count++;
      m_valid[wr_addr] = 1'b1;
      m_mem[wr_addr]   = wr_data;
    end
    if (busy_m) m_clr_left--;
    else if (clr_start) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_count = 0;
      m_clr_left = DEPTH;
    end
    m_ready = (m_clr_left == 0);
    @(posedge clk); #1;
    chk("wf_rd_valid", wf_rd_valid, e1_vld);
    chk("wf_rd_hit",   wf_rd_hit,   e1_hit_wf);
    chk("wf_rd_data",  wf_rd_data,  e1_dat_wf);
    chk("rf_rd_valid", rf_rd_valid, e1_vld);
    chk("rf_rd_hit",   rf_rd_hit,   e1_hit_rf);
    chk("rf_rd_data",  rf_rd_data,  e1_dat_rf);
    chk("or_rd_valid", or_rd_valid, e2_vld);
    chk("or_rd_hit",   or_rd_hit,   e2_hit);
    chk("or_rd_data",  or_rd_data,  e2_dat);
    chk("wf_busy", wf_busy, m_clr_left > 0);
    chk("rf_busy", rf_busy, m_clr_left > 0);
    chk("or_busy", or_busy, m_clr_left > 0);
    chk("wf_wr_ready", wf_wr_ready, m_ready);
    chk("wf_count", wf_entry_count, m_count);
    chk("rf_count", rf_entry_count, m_count);
    chk("or_count", or_entry_count, m_count);
  endtask

  typedef struct {
    bit          wr_en;
    logic [3:0]  wa;
    logic [15:0] wd;
    bit          rd_en;
    logic [3:0]  ra;
    bit          e_vld;
    bit          e_hit_wf;
    logic [15:0] e_dat_wf;
    bit          e_hit_rf;
    logic [15:0] e_dat_rf;
    int          e_cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    foreach (m_mem[i]) m_mem[i] = '0;
    model_reset();

    tbl[0] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 0};
    tbl[1] = '{1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1};
    tbl[2] = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1};
    tbl[3] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 1'b1, 16'h1234, 1'b1, 16'h1234, 1};
    tbl[4] = '{1'b1, 4'd6, 16'h5555, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2};
    tbl[5] = '{1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 1'b1, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 3};
    tbl[6] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b1, 1'b1, 16'hAAAA, 1'b1, 16'hAAAA, 3};
    tbl[7] = '{1'b1, 4'd5, 16'h0F0F, 1'b1, 4'd5, 1'b1, 1'b1, 16'h0F0F, 1'b1, 16'h1234, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", wf_rd_valid, 0);
    chk("rst_rd_data",  wf_rd_data, 0);
    chk("rst_busy",     wf_busy, 0);
    chk("rst_count",    wf_entry_count, 0);
    chk("rst_wr_ready", wf_wr_ready, 0);
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en = tbl[i].rd_en; rd_addr = tbl[i].ra; clr_start = 1'b0;
      cycle();
      chk($sformatf("tbl%0d_vld", i),    wf_rd_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_hit_wf", i), wf_rd_hit,   tbl[i].e_hit_wf);
      chk($sformatf("tbl%0d_dat_wf", i), wf_rd_data,  tbl[i].e_dat_wf);
      chk($sformatf("tbl%0d_hit_rf", i), rf_rd_hit,   tbl[i].e_hit_rf);
      chk($sformatf("tbl%0d_dat_rf", i), rf_rd_data,  tbl[i].e_dat_rf);
      chk($sformatf("tbl%0d_count", i),  wf_entry_count, tbl[i].e_cnt);
    end
    idle_inputs();

    // Fill every entry, then clear with a same-cycle write, a dropped write and an ignored restart
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'($urandom);
      cycle();
    end
    idle_inputs();
    chk("fill_count", wf_entry_count, 16);
    clr_start = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h7777;
    cycle();
    idle_inputs();
    busy_cycles = 0;
    for (int g = 0; g < 40 && wf_busy; g++) begin
      busy_cycles++;
      chk("sweep_wr_ready", wf_wr_ready, 0);
      if (g == 3) begin wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h9999; end
      if (g == 5) clr_start = 1'b1;
      cycle();
      idle_inputs();
    end
    chk("busy_len", busy_cycles, 16);
    chk("post_clr_count", wf_entry_count, 0);
    chk("post_clr_ready", wf_wr_ready, 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      cycle();
      chk("post_clr_hit", wf_rd_hit, 0);
      chk("post_clr_data", wf_rd_data, 0);
    end
    idle_inputs();

    // Output-register latency
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1357;
    cycle();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 4'd9;
    cycle();
    idle_inputs();
    chk("or_n1_vld", or_rd_valid, 0);
    cycle();
    chk("or_n2_vld", or_rd_valid, 1);
    chk("or_n2_hit", or_rd_hit, 1);
    chk("or_n2_data", or_rd_data, 16'h1357);

    // Reset in the middle of a sweep
    clr_start = 1'b1;
    cycle();
    idle_inputs();
    repeat (5) cycle();
    chk("pre_rst_busy", wf_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_wf", wf_busy, 0);
    chk("midrst_busy_or", or_busy, 0);
    chk("midrst_count", or_entry_count, 0);
    chk("midrst_ready", wf_wr_ready, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = 16'($urandom);
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      clr_start = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
